// File: rtl/i2c_arb_pkg.sv
// Shared types and field layout for the I2C request arbiter.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StLaunch,
    StWait,
    StResp
  } arb_state_t;

  localparam int unsigned I2C_WORD_W = 24;

  // Bit layout of the word handed to i2c_master: {wdata, addr, op, slv_addr}
  localparam int unsigned SLV_LSB  = 0;
  localparam int unsigned OP_BIT   = 7;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_LSB = 16;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  function automatic logic [I2C_WORD_W-1:0] pack_word(logic [6:0] slv, logic op,
                                                      logic [7:0] addr, logic [7:0] data);
    logic [I2C_WORD_W-1:0] w;
    w                  = '0;
    w[SLV_LSB +: 7]    = slv;
    w[OP_BIT]          = op;
    w[ADDR_LSB +: 8]   = addr;
    w[DATA_LSB +: 8]   = data;
    return w;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side request/response bundle for i2c_req_arbiter.
interface i2c_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7*NUM_REQ-1:0] req_slv_addr;
  logic [NUM_REQ-1:0]   req_op;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 rsp_nack;
  logic                 rsp_timeout;

  // Requester view
  modport master (
    output req_valid, req_slv_addr, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout
  );

  // Arbiter view
  modport slave (
    input  req_valid, req_slv_addr, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0] idx;
  logic            found;

  // First active request at last_grant+1, last_grant+2, ... (mod NUM_REQ)
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = IdxW'((32'(last_grant_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of i2c_master.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  resetn,
  i2c_req_arbiter_if.slave      req_bus,
  output logic                  I2C_trigger,
  output logic [I2C_WORD_W-1:0] addr_data_out,
  input  logic                  valid_data_ack,
  input  logic                  valid_data_ack_valid,
  input  logic [7:0]            rdata_out,
  input  logic                  rdata_out_valid,
  output logic                  rdata_out_valid_ack,
  input  logic                  PENDING_WR,
  input  logic                  PENDING_RD
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  arb_state_t state_q, state_d;

  logic [IdxW-1:0]       last_grant_q;
  logic [NUM_REQ-1:0]    win_oh_q;
  logic [IdxW-1:0]       win_idx_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [I2C_WORD_W-1:0] addr_data_q;
  logic [7:0]            rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_nack_q, rsp_nack_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               grant_load, word_load, rsp_load;
  logic [6:0]         sel_slv;
  logic               sel_op;
  logic [7:0]         sel_addr, sel_data;
  logic               op_read;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i        (req_bus.req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt),
    .gnt_idx_o    (arb_idx)
  );

  // Select the fields of the latched winner
  always_comb begin
    sel_slv  = '0;
    sel_op   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh_q[i]) begin
        sel_slv  = req_bus.req_slv_addr[7*i +: 7];
        sel_op   = req_bus.req_op[i];
        sel_addr = req_bus.req_addr[8*i +: 8];
        sel_data = req_bus.req_wdata[8*i +: 8];
      end
    end
  end

  assign op_read = (addr_data_q[OP_BIT] == OP_READ);

  // Next-state, handshake outputs and response capture
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    grant_load          = 1'b0;
    word_load           = 1'b0;
    rsp_load            = 1'b0;
    rsp_rdata_d         = rsp_rdata_q;
    rsp_nack_d          = rsp_nack_q;
    rsp_timeout_d       = rsp_timeout_q;
    req_bus.req_ready   = '0;
    req_bus.rsp_valid   = '0;
    I2C_trigger         = 1'b0;
    rdata_out_valid_ack = 1'b0;

    case (state_q)
      StIdle: begin
        if ((|req_bus.req_valid) && !(PENDING_WR || PENDING_RD)) begin
          grant_load = 1'b1;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        req_bus.req_ready = win_oh_q;
        // A winner that withdrew its request is dropped without a transaction
        if (|(req_bus.req_valid & win_oh_q)) begin
          word_load = 1'b1;
          state_d   = StLaunch;
        end else begin
          state_d = StIdle;
        end
      end
      StLaunch: begin
        I2C_trigger = 1'b1;
        cnt_d       = '0;
        state_d     = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // Completion has priority over a timeout expiring in the same cycle
        if (op_read && rdata_out_valid) begin
          rdata_out_valid_ack = 1'b1;
          rsp_load            = 1'b1;
          rsp_rdata_d         = rdata_out;
          rsp_nack_d          = 1'b0;
          rsp_timeout_d       = 1'b0;
          state_d             = StResp;
        end else if ((addr_data_q[OP_BIT] == OP_WRITE) && valid_data_ack_valid) begin
          rsp_load      = 1'b1;
          rsp_rdata_d   = '0;
          rsp_nack_d    = ~valid_data_ack;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rsp_load      = 1'b1;
          rsp_rdata_d   = '0;
          rsp_nack_d    = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end
      end
      StResp: begin
        req_bus.rsp_valid = win_oh_q;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, winner, master word and response registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      last_grant_q  <= IdxW'(NUM_REQ - 1);
      win_oh_q      <= '0;
      win_idx_q     <= '0;
      cnt_q         <= '0;
      addr_data_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant_load) begin
        win_oh_q  <= arb_gnt;
        win_idx_q <= arb_idx;
      end
      if (word_load) begin
        addr_data_q  <= pack_word(sel_slv, sel_op, sel_addr, sel_data);
        last_grant_q <= win_idx_q;
      end
      if (rsp_load) begin
        rsp_rdata_q   <= rsp_rdata_d;
        rsp_nack_q    <= rsp_nack_d;
        rsp_timeout_q <= rsp_timeout_d;
      end
    end
  end

  assign addr_data_out       = addr_data_q;
  assign req_bus.rsp_rdata   = rsp_rdata_q;
  assign req_bus.rsp_nack    = rsp_nack_q;
  assign req_bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: vector table plus multi-cycle corner sequences.
module tb_i2c_req_arbiter;

  localparam int unsigned NumReq        = 2;
  localparam int unsigned TimeoutCycles = 16;

  localparam int CplAck  = 0;
  localparam int CplNack = 1;
  localparam int CplRead = 2;
  localparam int CplNone = 3;

  typedef struct {
    string           name;
    logic [1:0]      valid;
    logic [1:0]      op;
    logic [1:0][6:0] slv;
    logic [1:0][7:0] addr;
    logic [1:0][7:0] wdata;
    int              cpl;
    logic [7:0]      mrdata;
    int              exp_win;
    logic [23:0]     exp_word;
    logic [7:0]      exp_rdata;
    logic            exp_nack;
    logic            exp_to;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        I2C_trigger;
  logic [23:0] addr_data_out;
  logic        valid_data_ack, valid_data_ack_valid;
  logic [7:0]  rdata_out;
  logic        rdata_out_valid, rdata_out_valid_ack;
  logic        PENDING_WR, PENDING_RD;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter_if #(.NUM_REQ(NumReq)) bus ();

  i2c_req_arbiter #(
    .NUM_REQ        (NumReq),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .req_bus              (bus),
    .I2C_trigger          (I2C_trigger),
    .addr_data_out        (addr_data_out),
    .valid_data_ack       (valid_data_ack),
    .valid_data_ack_valid (valid_data_ack_valid),
    .rdata_out            (rdata_out),
    .rdata_out_valid      (rdata_out_valid),
    .rdata_out_valid_ack  (rdata_out_valid_ack),
    .PENDING_WR           (PENDING_WR),
    .PENDING_RD           (PENDING_RD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic master_idle();
    valid_data_ack_valid = 1'b0;
    valid_data_ack       = 1'b0;
    rdata_out_valid      = 1'b0;
    rdata_out            = 8'h00;
  endtask

  task automatic set_req(input int idx, input logic op, input logic [6:0] slv,
                         input logic [7:0] addr, input logic [7:0] wdata);
    bus.req_op[idx]             = op;
    bus.req_slv_addr[7*idx +: 7] = slv;
    bus.req_addr[8*idx +: 8]     = addr;
    bus.req_wdata[8*idx +: 8]    = wdata;
  endtask

  function automatic vec_t mk(string name, logic [1:0] valid, logic [1:0] op,
                              logic [13:0] slv, logic [15:0] addr, logic [15:0] wdata,
                              int cpl, logic [7:0] mrdata, int win, logic [23:0] word,
                              logic [7:0] rd, logic nack, logic to);
    vec_t v;
    v.name = name; v.valid = valid; v.op = op; v.slv = slv; v.addr = addr;
    v.wdata = wdata; v.cpl = cpl; v.mrdata = mrdata; v.exp_win = win;
    v.exp_word = word; v.exp_rdata = rd; v.exp_nack = nack; v.exp_to = to;
    return v;
  endfunction

  // Called at a negedge with the FSM in IDLE; returns at a negedge back in IDLE.
  task automatic run_vec(input vec_t v);
    int n;
    bus.req_slv_addr = v.slv;
    bus.req_op       = v.op;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_valid    = v.valid;
    step();
    chk({v.name, ":ready"}, 32'(bus.req_ready), 32'(1 << v.exp_win));
    step();
    chk({v.name, ":trigger"}, 32'(I2C_trigger), 32'd1);
    chk({v.name, ":word"}, 32'(addr_data_out), 32'(v.exp_word));
    bus.req_valid = bus.req_valid & ~(2'b01 << v.exp_win);
    step();
    chk({v.name, ":trigger_pulse"}, 32'(I2C_trigger), 32'd0);
    case (v.cpl)
      CplAck, CplNack: begin
        valid_data_ack_valid = 1'b1;
        valid_data_ack       = (v.cpl == CplAck);
        step();
        master_idle();
      end
      CplRead: begin
        rdata_out_valid = 1'b1;
        rdata_out       = v.mrdata;
        #1;
        chk({v.name, ":rd_ack"}, 32'(rdata_out_valid_ack), 32'd1);
        step();
        master_idle();
      end
      default: begin
        // WAIT counts 0..TimeoutCycles-1; response follows the last count
        n = 0;
        while (bus.rsp_valid == '0 && n < 40) begin
          step();
          n++;
        end
        chk({v.name, ":timeout_cycles"}, 32'(n), 32'(TimeoutCycles));
      end
    endcase
    chk({v.name, ":rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << v.exp_win));
    chk({v.name, ":rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    chk({v.name, ":rsp_nack"}, 32'(bus.rsp_nack), 32'(v.exp_nack));
    chk({v.name, ":rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.exp_to));
    step();
    chk({v.name, ":rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    int bad;

    vecs[0]  = mk("wr_ack", 2'b01, 2'b00, {7'h00, 7'h50}, {8'h00, 8'h10}, {8'h00, 8'hA5},
                  CplAck, 8'h00, 0, 24'hA51050, 8'h00, 1'b0, 1'b0);
    vecs[1]  = mk("rd", 2'b10, 2'b10, {7'h50, 7'h00}, {8'h20, 8'h00}, 16'h0000,
                  CplRead, 8'h3C, 1, 24'h0020D0, 8'h3C, 1'b0, 1'b0);
    vecs[2]  = mk("fair0", 2'b11, 2'b10, {7'h22, 7'h21}, {8'h02, 8'h01}, {8'h00, 8'h11},
                  CplAck, 8'h00, 0, 24'h110121, 8'h00, 1'b0, 1'b0);
    vecs[3]  = mk("fair1", 2'b11, 2'b10, {7'h22, 7'h21}, {8'h02, 8'h01}, {8'h00, 8'h11},
                  CplRead, 8'h5A, 1, 24'h0002A2, 8'h5A, 1'b0, 1'b0);
    vecs[4]  = mk("fair2", 2'b11, 2'b10, {7'h22, 7'h21}, {8'h02, 8'h01}, {8'h00, 8'h11},
                  CplAck, 8'h00, 0, 24'h110121, 8'h00, 1'b0, 1'b0);
    vecs[5]  = mk("fair3", 2'b11, 2'b10, {7'h22, 7'h21}, {8'h02, 8'h01}, {8'h00, 8'h11},
                  CplRead, 8'hA5, 1, 24'h0002A2, 8'hA5, 1'b0, 1'b0);
    vecs[6]  = mk("fair4", 2'b11, 2'b10, {7'h22, 7'h21}, {8'h02, 8'h01}, {8'h00, 8'h11},
                  CplAck, 8'h00, 0, 24'h110121, 8'h00, 1'b0, 1'b0);
    vecs[7]  = mk("fair5", 2'b11, 2'b10, {7'h22, 7'h21}, {8'h02, 8'h01}, {8'h00, 8'h11},
                  CplRead, 8'hC3, 1, 24'h0002A2, 8'hC3, 1'b0, 1'b0);
    vecs[8]  = mk("wr_nack", 2'b01, 2'b00, {7'h00, 7'h50}, {8'h00, 8'h11}, 16'h0000,
                  CplNack, 8'h00, 0, 24'h001150, 8'h00, 1'b1, 1'b0);
    vecs[9]  = mk("wr_timeout", 2'b10, 2'b00, {7'h33, 7'h00}, {8'h44, 8'h00},
                  {8'h55, 8'h00}, CplNone, 8'h00, 1, 24'h554433, 8'h00, 1'b0, 1'b1);
    vecs[10] = mk("rd_timeout", 2'b01, 2'b01, {7'h00, 7'h7F}, {8'h00, 8'hFF}, 16'h0000,
                  CplNone, 8'h00, 0, 24'h00FFFF, 8'h00, 1'b0, 1'b1);

    resetn           = 1'b0;
    PENDING_WR       = 1'b0;
    PENDING_RD       = 1'b0;
    bus.req_valid    = '0;
    bus.req_op       = '0;
    bus.req_slv_addr = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    master_idle();
    step();
    step();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_trigger", 32'(I2C_trigger), 32'd0);
    chk("rst_word", 32'(addr_data_out), 32'd0);
    chk("rst_rsp_fields", 32'({bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout}), 32'd0);
    chk("rst_rd_ack", 32'(rdata_out_valid_ack), 32'd0);
    resetn = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Busy gating: no grant while the master reports pending work
    PENDING_WR = 1'b1;
    PENDING_RD = 1'b1;
    set_req(1, 1'b0, 7'h12, 8'h34, 8'h56);
    bus.req_valid = 2'b10;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) PENDING_WR = 1'b0;
      step();
      if (bus.req_ready != '0 || I2C_trigger) bad++;
    end
    chk("busy_no_grant", 32'(bad), 32'd0);
    PENDING_RD = 1'b0;
    step();
    chk("busy_release_ready", 32'(bus.req_ready), 32'b10);
    step();
    chk("busy_trigger", 32'(I2C_trigger), 32'd1);
    chk("busy_word", 32'(addr_data_out), 32'h563412);
    bus.req_valid = '0;
    step();
    valid_data_ack_valid = 1'b1;
    valid_data_ack       = 1'b1;
    step();
    master_idle();
    chk("busy_rsp", 32'({bus.rsp_valid, bus.rsp_nack}), 32'b100);
    step();

    // Completion in the final timeout cycle wins over the timeout
    set_req(0, 1'b0, 7'h0A, 8'h0B, 8'h0C);
    bus.req_valid = 2'b01;
    step();
    chk("edge_ready", 32'(bus.req_ready), 32'b01);
    step();
    bus.req_valid = '0;
    repeat (TimeoutCycles) step();
    chk("edge_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
    valid_data_ack_valid = 1'b1;
    valid_data_ack       = 1'b1;
    step();
    master_idle();
    chk("edge_rsp_valid", 32'(bus.rsp_valid), 32'b01);
    chk("edge_no_timeout", 32'({bus.rsp_timeout, bus.rsp_nack}), 32'd0);
    step();

    // Wrong-type completion ignored; both together use the matching one
    set_req(1, 1'b1, 7'h44, 8'h55, 8'h00);
    bus.req_valid = 2'b10;
    step();
    chk("mix_ready", 32'(bus.req_ready), 32'b10);
    step();
    bus.req_valid = '0;
    step();
    valid_data_ack_valid = 1'b1;
    valid_data_ack       = 1'b0;
    #1;
    chk("mix_no_rd_ack", 32'(rdata_out_valid_ack), 32'd0);
    step();
    master_idle();
    chk("mix_ignored", 32'(bus.rsp_valid), 32'd0);
    rdata_out_valid      = 1'b1;
    rdata_out            = 8'h99;
    valid_data_ack_valid = 1'b1;
    valid_data_ack       = 1'b0;
    #1;
    chk("mix_rd_ack", 32'(rdata_out_valid_ack), 32'd1);
    step();
    master_idle();
    chk("mix_rsp_valid", 32'(bus.rsp_valid), 32'b10);
    chk("mix_rsp", 32'({bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout}), 32'({8'h99, 2'b00}));
    step();

    // Winner withdraws during GRANT: no launch, the other requester follows
    set_req(0, 1'b0, 7'h01, 8'h02, 8'h03);
    set_req(1, 1'b1, 7'h04, 8'h05, 8'h00);
    bus.req_valid = 2'b11;
    step();
    chk("drop_ready0", 32'(bus.req_ready), 32'b01);
    bus.req_valid = 2'b10;
    step();
    chk("drop_no_launch", 32'({bus.req_ready, I2C_trigger}), 32'd0);
    step();
    chk("drop_ready1", 32'(bus.req_ready), 32'b10);
    step();
    chk("drop_word", 32'({I2C_trigger, addr_data_out}), 32'h1000584);
    bus.req_valid = '0;
    step();
    rdata_out_valid = 1'b1;
    rdata_out       = 8'h77;
    step();
    master_idle();
    chk("drop_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'h277);
    step();

    // Reset in WAIT aborts silently and restarts arbitration at requester 0
    set_req(0, 1'b0, 7'h60, 8'h61, 8'h62);
    bus.req_valid = 2'b01;
    step();
    step();
    bus.req_valid = '0;
    step();
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("wrst_ready_rsp", 32'({bus.req_ready, bus.rsp_valid}), 32'd0);
    chk("wrst_trigger_ack", 32'({I2C_trigger, rdata_out_valid_ack}), 32'd0);
    chk("wrst_word", 32'(addr_data_out), 32'd0);
    chk("wrst_rsp_fields", 32'({bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout}), 32'd0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.rsp_valid != '0 || I2C_trigger) bad++;
    end
    chk("wrst_no_rsp", 32'(bad), 32'd0);
    set_req(1, 1'b0, 7'h70, 8'h71, 8'h72);
    bus.req_valid = 2'b11;
    step();
    chk("wrst_first_grant", 32'(bus.req_ready), 32'b01);
    step();
    chk("wrst_word_after", 32'(addr_data_out), 32'h626160);
    bus.req_valid = '0;
    step();
    valid_data_ack_valid = 1'b1;
    valid_data_ack       = 1'b1;
    step();
    master_idle();
    chk("wrst_rsp", 32'(bus.rsp_valid), 32'b01);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
